// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM state encoding and key-code helper for the keypad scanner.
package keypad_pkg;
    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} kp_state_t;
    function automatic int kp_code(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction
endpackage

// File: rtl/keypad_tick_gen.sv
// keypad_tick_gen: divider producing a one-cycle tick every DIV clock cycles.
//   i_clock  in  system clock
//   i_reset  in  synchronous, active-low
//   o_tick   out one-cycle pulse every DIV cycles
module keypad_tick_gen #(
    parameter int DIV = 250000
) (
    input  logic i_clock,
    input  logic i_reset,
    output logic o_tick
);
    localparam int W = $clog2(DIV);
    logic [W-1:0] r_cnt;
    assign o_tick = r_cnt == W'(DIV - 1);
    always_ff @(posedge i_clock) begin
        if (!i_reset) r_cnt <= '0;
        else          r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: ROWSxCOLS keypad scanner with debounce and a valid/ready key-event output.
//   i_clock         in  system clock
//   i_reset         in  synchronous, active-low
//   i_keypad_col    in  column sense, active-low, asynchronous
//   o_keypad_row    out row drive, one-cold
//   o_key_valid     out event available
//   i_key_ready     in  consumer accepts the event
//   o_key_code      out row*COLS+col of the event key
//   o_key_down      out a debounced key is currently held
//   o_key_overflow  out one-cycle pulse when an event is dropped
// Define KEYPAD_REPEAT_EN to enable auto-repeat while a key is held.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_DIV       = 250000,
    parameter int DEBOUNCE_TICKS = 4
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_DELAY   = 120,
    parameter int REPEAT_RATE    = 30
`endif
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic [COLS-1:0]                 i_keypad_col,
    output logic [ROWS-1:0]                 o_keypad_row,
    output logic                            o_key_valid,
    input  logic                            i_key_ready,
    output logic [$clog2(ROWS*COLS)-1:0]    o_key_code,
    output logic                            o_key_down,
    output logic                            o_key_overflow
);
    localparam int CODE_W = $clog2(ROWS * COLS);
    localparam int RW     = $clog2(ROWS);
    localparam int CW     = $clog2(COLS);
    localparam int DW     = $clog2(DEBOUNCE_TICKS + 2);

    logic              w_tick;
    logic [COLS-1:0]   r_col_s1, r_col_s2;
    kp_state_t         r_state, w_state_n;
    logic [RW-1:0]     r_row, w_row_n, w_row_inc;
    logic [CW-1:0]     r_col, w_col_n, w_low_idx;
    logic [DW-1:0]     r_cnt, w_cnt_n, w_cnt_inc;
    logic              r_down, w_down_n;
    logic              w_any_low, w_col_low, w_press_emit, w_rep_emit, w_emit;
    logic              r_valid, r_overflow;
    logic [CODE_W-1:0] r_code;

    keypad_tick_gen #(.DIV(SCAN_DIV)) u_tick (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .o_tick  (w_tick)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_col_s1 <= '1;
            r_col_s2 <= '1;
        end else begin
            r_col_s1 <= i_keypad_col;
            r_col_s2 <= r_col_s1;
        end
    end

    assign w_any_low    = ~&r_col_s2;
    assign w_col_low    = ~r_col_s2[r_col];
    assign w_row_inc    = (r_row == RW'(ROWS - 1)) ? '0 : r_row + 1'b1;
    assign w_cnt_inc    = r_cnt + 1'b1;
    assign o_keypad_row = ~(ROWS'(1) << r_row);

    // Lowest-index low column wins when several are pressed together.
    always_comb begin
        w_low_idx = '0;
        for (int c = COLS - 1; c >= 0; c--)
            if (!r_col_s2[c]) w_low_idx = CW'(c);
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state <= SCAN;
            r_row   <= '0;
            r_col   <= '0;
            r_cnt   <= '0;
            r_down  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_row   <= w_row_n;
            r_col   <= w_col_n;
            r_cnt   <= w_cnt_n;
            r_down  <= w_down_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_row_n      = r_row;
        w_col_n      = r_col;
        w_cnt_n      = r_cnt;
        w_down_n     = r_down;
        w_press_emit = 1'b0;
        if (w_tick) begin
            case (r_state)
                SCAN: begin
                    if (w_any_low) begin
                        w_col_n   = w_low_idx;
                        w_cnt_n   = DW'(1);
                        w_state_n = PRESS_DB;
                    end else w_row_n = w_row_inc;
                end
                PRESS_DB: begin
                    if (w_col_low) begin
                        w_cnt_n = w_cnt_inc;
                        if (w_cnt_inc >= DW'(DEBOUNCE_TICKS)) begin
                            w_press_emit = 1'b1;
                            w_down_n     = 1'b1;
                            w_state_n    = HELD;
                        end
                    end else w_state_n = SCAN;
                end
                HELD: begin
                    if (!w_col_low) begin
                        w_cnt_n   = DW'(1);
                        w_state_n = REL_DB;
                    end
                end
                default: begin
                    if (!w_col_low) begin
                        w_cnt_n = w_cnt_inc;
                        if (w_cnt_inc >= DW'(DEBOUNCE_TICKS)) begin
                            w_down_n  = 1'b0;
                            w_row_n   = w_row_inc;
                            w_state_n = SCAN;
                        end
                    end else w_state_n = HELD;
                end
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    logic [REP_W-1:0] r_rep, w_rep_inc, w_rep_lim;
    logic             r_rep_arm, w_rep_step;
    // The counter is held at zero outside HELD, so every entry to HELD starts a fresh delay.
    assign w_rep_step = w_tick && r_state == HELD && w_col_low;
    assign w_rep_inc  = r_rep + 1'b1;
    assign w_rep_lim  = r_rep_arm ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY);
    assign w_rep_emit = w_rep_step && w_rep_inc == w_rep_lim;
    always_ff @(posedge i_clock) begin
        if (!i_reset || r_state != HELD) begin
            r_rep     <= '0;
            r_rep_arm <= 1'b0;
        end else if (w_rep_step) begin
            r_rep     <= w_rep_emit ? '0 : w_rep_inc;
            r_rep_arm <= r_rep_arm | w_rep_emit;
        end
    end
`else
    assign w_rep_emit = 1'b0;
`endif

    assign w_emit = w_press_emit | w_rep_emit;

    // A pending event is never replaced; a colliding emit is reported and dropped.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_valid    <= 1'b0;
            r_code     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_emit && r_valid;
            if (w_emit && !r_valid) begin
                r_valid <= 1'b1;
                r_code  <= CODE_W'(kp_code(int'(r_row), int'(r_col), COLS));
            end else if (r_valid && i_key_ready) r_valid <= 1'b0;
        end
    end

    assign o_key_valid    = r_valid;
    assign o_key_code     = r_code;
    assign o_key_down     = r_down;
    assign o_key_overflow = r_overflow;
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: scoreboard bench for the keypad scanner with a modelled key matrix.
module tb_keypad_matrix_scanner;
    localparam int ROWS = 4;
    localparam int COLS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_ready = 1'b0;
    logic [3:0]  col, row, code;
    logic        valid, down, ovf;
    logic [15:0] pressed = '0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_ovf = 0;
    int          n_evt = 0;
    int          exp_q[$];

    always #5 clk = ~clk;

    keypad_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DEBOUNCE_TICKS(3)
`ifdef KEYPAD_REPEAT_EN
        , .REPEAT_DELAY(5), .REPEAT_RATE(2)
`endif
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_keypad_col   (col),
        .o_keypad_row   (row),
        .o_key_valid    (valid),
        .i_key_ready    (key_ready),
        .o_key_code     (code),
        .o_key_down     (down),
        .o_key_overflow (ovf)
    );

    always_comb begin
        col = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (pressed[r*COLS+c] && !row[r]) col[c] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ovf) n_ovf++;
            if (valid && key_ready) begin
                n_evt++;
                if (exp_q.size() == 0) check("unexpected_evt", valid, 1'b0);
                else check("evt_code", code, exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        cyc(4 * n);
    endtask

    task automatic wait_valid(input string tag);
        int i = 0;
        while (!valid && i < 200) begin
            cyc(1);
            i++;
        end
        check(tag, valid, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_row"}, row, 4'b1110);
        check({tag, "_valid"}, valid, 1'b0);
        check({tag, "_code"}, code, 0);
        check({tag, "_down"}, down, 1'b0);
        check({tag, "_ovf"}, ovf, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int e0;
        key_ready = 1'b1;
        rst_n = 1'b0;
        cyc(2);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        exp_q.push_back(9);
        pressed[9] = 1'b1;
        ticks(12);
        check("t1_down_held", down, 1'b1);
        ticks(8);
        pressed = '0;
        ticks(10);
        check("t1_down_rel", down, 1'b0);

        e0 = n_evt;
        for (int i = 0; i < 16; i++) begin
            pressed[1] = ~pressed[1];
            cyc(4);
        end
        check("t2_bounce_no_evt", n_evt, e0);
        exp_q.push_back(1);
        pressed[1] = 1'b1;
        ticks(12);
        pressed = '0;
        ticks(10);

        key_ready = 1'b0;
        e0 = n_ovf;
        exp_q.push_back(5);
        pressed[5] = 1'b1;
        ticks(12);
        pressed = '0;
        ticks(8);
        pressed[10] = 1'b1;
        ticks(12);
        pressed = '0;
        ticks(8);
        check("t3_valid_held", valid, 1'b1);
        check("t3_code_held", code, 5);
        check("t3_ovf_pulses", n_ovf - e0, 1);
        key_ready = 1'b1;
        cyc(2);
        check("t3_valid_drop", valid, 1'b0);

        exp_q.push_back(13);
        pressed[13] = 1'b1;
        pressed[15] = 1'b1;
        ticks(12);
        pressed[15] = 1'b0;
        ticks(8);
        check("t4_down_after_col3", down, 1'b1);
        pressed = '0;
        ticks(10);
        check("t4_down_rel", down, 1'b0);

        e0 = n_evt;
        rst_n = 1'b0;
        pressed[2] = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        cyc(6);
        rst_n = 1'b0;
        cyc(1);
        pressed = '0;
        rst_n = 1'b1;
        check_reset_outputs("t5a");
        ticks(10);
        check("t5a_no_evt", n_evt, e0);
        check("t5a_down", down, 1'b0);

        key_ready = 1'b0;
        pressed[3] = 1'b1;
        wait_valid("t5b_valid");
        check("t5b_code", code, 3);
        check("t5b_down", down, 1'b1);
        rst_n = 1'b0;
        pressed = '0;
        cyc(1);
        rst_n = 1'b1;
        check_reset_outputs("t5b");
        key_ready = 1'b1;
        e0 = n_evt;
        ticks(10);
        check("t5b_no_evt", n_evt, e0);

`ifdef KEYPAD_REPEAT_EN
        e0 = n_evt;
        repeat (5) exp_q.push_back(7);
        pressed[7] = 1'b1;
        wait_valid("t6_first_valid");
        cyc(44);
        pressed = '0;
        ticks(10);
        check("t6_repeat_count", n_evt - e0, 5);
`endif

        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
